// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline sequencer and the rest of the core.
// The core side drives hazard inputs; the sequencer drives enables, flushes and forwarding.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_regWr;
  logic             ex_dREN;
  logic [4:0]       ex_dst;
  logic             ex_br_taken;
  logic             mem_regWr;
  logic [4:0]       mem_dst;
  logic             mem_dreq;
  logic             dhit;
  logic [31:0]      mem_result;
  logic [31:0]      wb_data;
  logic             mem_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             srcA;
  logic             srcB;
  logic [31:0]      forA;
  logic [31:0]      forB;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_regWr, ex_dREN, ex_dst, ex_br_taken,
           mem_regWr, mem_dst, mem_dreq, dhit, mem_result, wb_data, mem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, srcA, srcB, forA, forB, halted, stall_cnt
  );

  modport slave (
    input  ihit, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_regWr, ex_dREN, ex_dst, ex_br_taken,
           mem_regWr, mem_dst, mem_dreq, dhit, mem_result, wb_data, mem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, srcA, srcB, forA, forB, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables/flushes, load-use bubbles,
// cache-miss freeze, branch squash, halt, and registered EX operand forwarding selects.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic           CLK,
  input logic           nRST,
  hazard_ctrl_if.slave  hif
);

  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALT = 2'd2} state_t;
  typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_t;

  state_t           state, next_state;
  fwd_t             selA, selB;
  fwd_t             decA, decB;
  logic             freeze;
  logic             load_use;
  logic [CNT_W-1:0] cnt;

  // EX result beats MEM result when both target the same register (it is younger).
  function automatic fwd_t decide(input logic use_r, input logic [4:0] r,
                                  input logic ex_wr, input logic [4:0] ex_d,
                                  input logic mem_wr, input logic [4:0] mem_d);
    fwd_t f;
    f = FWD_NONE;
    if (use_r && (r != 5'd0)) begin
      if (ex_wr && (ex_d == r))
        f = FWD_MEM;
      else if (mem_wr && (mem_d == r))
        f = FWD_WB;
    end
    return f;
  endfunction

  assign freeze = hif.mem_dreq && !hif.dhit;

  assign load_use = hif.ex_dREN && hif.ex_regWr && (hif.ex_dst != 5'd0) &&
                    ((hif.id_use_rs && (hif.id_rs == hif.ex_dst)) ||
                     (hif.id_use_rt && (hif.id_rt == hif.ex_dst)));

  assign decA = decide(hif.id_use_rs, hif.id_rs, hif.ex_regWr, hif.ex_dst,
                       hif.mem_regWr, hif.mem_dst);
  assign decB = decide(hif.id_use_rt, hif.id_rt, hif.ex_regWr, hif.ex_dst,
                       hif.mem_regWr, hif.mem_dst);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= RUN;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (hif.mem_halt)
      next_state = HALT;
    else begin
      case (state)
        RUN:     if (freeze) next_state = DWAIT;
        DWAIT:   if (hif.dhit) next_state = RUN;
        HALT:    next_state = HALT;
        default: next_state = RUN;
      endcase
    end
  end

  always_comb begin
    hif.pc_en      = 1'b0;
    hif.ifid_en    = 1'b0;
    hif.idex_en    = 1'b0;
    hif.exmem_en   = 1'b0;
    hif.memwb_en   = 1'b0;
    hif.ifid_flush = 1'b0;
    hif.idex_flush = 1'b0;
    if (!nRST || (state == HALT) || freeze) begin
      hif.pc_en = 1'b0;
    end else if (hif.ex_br_taken) begin
      hif.pc_en      = 1'b1;
      hif.ifid_en    = 1'b1;
      hif.idex_en    = 1'b1;
      hif.exmem_en   = 1'b1;
      hif.memwb_en   = 1'b1;
      hif.ifid_flush = 1'b1;
      hif.idex_flush = 1'b1;
    end else if (load_use) begin
      hif.idex_en    = 1'b1;
      hif.exmem_en   = 1'b1;
      hif.memwb_en   = 1'b1;
      hif.idex_flush = 1'b1;
    end else if (!hif.ihit) begin
      hif.ifid_en    = 1'b1;
      hif.idex_en    = 1'b1;
      hif.exmem_en   = 1'b1;
      hif.memwb_en   = 1'b1;
      hif.ifid_flush = 1'b1;
    end else begin
      hif.pc_en      = 1'b1;
      hif.ifid_en    = 1'b1;
      hif.idex_en    = 1'b1;
      hif.exmem_en   = 1'b1;
      hif.memwb_en   = 1'b1;
    end
  end

  assign hif.halted = (state == HALT);

  // Selects follow the instruction into EX; a bubble into EX carries no forwarding.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      selA <= FWD_NONE;
      selB <= FWD_NONE;
    end else if (hif.idex_flush) begin
      selA <= FWD_NONE;
      selB <= FWD_NONE;
    end else if (hif.idex_en) begin
      selA <= decA;
      selB <= decB;
    end
  end

  always_comb begin
    hif.srcA = (selA != FWD_NONE);
    hif.srcB = (selB != FWD_NONE);
    case (selA)
      FWD_MEM: hif.forA = hif.mem_result;
      FWD_WB:  hif.forA = hif.wb_data;
      default: hif.forA = 32'd0;
    endcase
    case (selB)
      FWD_MEM: hif.forB = hif.mem_result;
      FWD_WB:  hif.forB = hif.wb_data;
      default: hif.forB = 32'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt <= '0;
    else if (!hif.pc_en && (state != HALT) && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + CNT_W'(1);
  end

  assign hif.stall_cnt = cnt;

endmodule
